shot_clock_ctrl: RTL and testbench
==================================

Name: shot_clock_ctrl

Overview:
Run/pause/reload sequencer for the 24-second shot-clock counter. It conditions three front-panel keys and runs the clock through IDLE, RUN, PAUSE and EXPIRED states. It drives the counter's run enable and synchronous load (24 s or 14 s), monitors the counter's BCD digits for expiry, and times the expiry horn. It sits between the panel keys, the 1 Hz tick from the clock divider, and the countdown counter / 7-segment path.

Parameters:
DEB_CYCLES, 20, consecutive stable CLK_50 samples required to accept a key level (width of the debounce counter derived from this value)
ALARM_TICKS, 3, number of tick pulses Alarm stays high after expiry
LOAD_LONG, 8'h24, BCD reload value for the full shot clock
LOAD_SHORT, 8'h14, BCD reload value for the offensive-rebound reset

Ports:
CLK_50  input  1  system clock; all logic is on its rising edge
nRST  input  1  asynchronous, active-low reset
tick  input  1  1-cycle enable pulse at 1 Hz from the divider, synchronous to CLK_50
nKEY_START  input  1  raw active-low key; toggles run/pause
nKEY_R24  input  1  raw active-low key; reload LOAD_LONG
nKEY_R14  input  1  raw active-low key; reload LOAD_SHORT
TimerH  input  4  counter tens digit, BCD
TimerL  input  4  counter units digit, BCD
load  output  1  1-cycle pulse; counter loads load_val
load_val  output  8  BCD reload value {tens, units}
cnt_run  output  1  counter count enable (counter pause = ~cnt_run)
Alarm  output  1  expiry horn
state  output  2  IDLE=00, RUN=01, PAUSE=10, EXPIRED=11

Behaviour:
- Reset (async assert, sync release): state=IDLE, load=0, load_val=LOAD_LONG, cnt_run=0, Alarm=0, alarm counter=0, debounced key levels=1 (released), debounce counters=0.
- Key conditioning, per key:
  - 2-FF synchroniser, then debounce.
  - The accepted level updates only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles; any bounce resets the count.
  - An accepted 1→0 transition produces a one-cycle press pulse (pS, p24, p14). Releases produce nothing.
  - Latency from a clean edge to the press pulse: 2 + DEB_CYCLES cycles, ±1.
- Press priority in the same cycle: p24 > p14 > pS; lower-priority presses in that cycle are dropped.
- zero = (TimerH==0 && TimerL==0). Non-BCD digit values count as nonzero.
- All outputs are registered; each action takes effect one cycle after the cycle that causes it.
- Reload action (p24 or p14):
  - load=1 for exactly one cycle.
  - load_val ← LOAD_LONG or LOAD_SHORT and holds until the next reload.
- IDLE:
  - pS → RUN.
  - Reload → reload action, stay IDLE.
- RUN:
  - Reload → reload action, stay RUN. This takes precedence over expiry in the same cycle.
  - Otherwise pS → PAUSE.
  - Otherwise zero → EXPIRED: Alarm←1, alarm counter←0.
- PAUSE:
  - pS → RUN.
  - Reload → reload action, stay PAUSE.
  - zero is ignored.
- EXPIRED:
  - pS is ignored.
  - Reload → reload action, go to IDLE, Alarm←0 immediately, alarm counter←0.
  - While Alarm=1, each tick increments the alarm counter. On the tick where the counter equals ALARM_TICKS-1, Alarm←0 and the state stays EXPIRED.
- cnt_run = 1 iff the next state is RUN, registered with state; it is never high in IDLE, PAUSE or EXPIRED.
- pS in IDLE while zero: enter RUN, then EXPIRED on the following cycle. No tick is required for expiry.
- tick has no effect on state transitions; it only times Alarm.
- Reset asserted mid-run or mid-alarm: all outputs return to their reset values asynchronously. No load pulse is generated on release.

Test Plan:
- Reset + debounce: hold nRST=0, then release with keys high → state=00, cnt_run=0, load=0, load_val=8'h24, Alarm=0. Bounce nKEY_START 3 times shorter than DEB_CYCLES, then hold low → exactly one pS; state=01 and cnt_run=1 at edge+2+DEB_CYCLES(±1)+1.
- Run/pause: in RUN with Timer=8'h17, press START → state=10, cnt_run=0. Press START again → state=01, cnt_run=1. Timer=00 while in PAUSE → no expiry.
- Expiry/horn: in RUN, drive Timer=00 → next cycle state=11, cnt_run=0, Alarm=1. Alarm stays high for exactly 3 tick pulses, then 0; state stays 11. Press START → no change.
- Reload from EXPIRED: press R14 with Alarm=1 → one-cycle load=1, load_val=8'h14, Alarm=0, state=00.
- Priority/collision: p24 and p14 in the same cycle → load_val=8'h24. In RUN, drive Timer=00 in the same cycle as p14 → load pulse, state stays 01, no Alarm.
- Reset mid-alarm: assert nRST while Alarm=1 → Alarm=0, state=00 immediately, with no waiting for a clock edge.

Source files
------------

// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencer: key conditioning, run/pause/expire FSM,
// reload strobes and expiry horn timing.
module shot_clock_ctrl #(
    parameter int       DEB_CYCLES  = 20,
    parameter int       ALARM_TICKS = 3,
    parameter bit [7:0] LOAD_LONG   = 8'h24,
    parameter bit [7:0] LOAD_SHORT  = 8'h14
) (
    input  logic       CLK_50,
    input  logic       nRST,
    input  logic       tick,
    input  logic       nKEY_START,
    input  logic       nKEY_R24,
    input  logic       nKEY_R14,
    input  logic [3:0] TimerH,
    input  logic [3:0] TimerL,
    output logic       load,
    output logic [7:0] load_val,
    output logic       cnt_run,
    output logic       Alarm,
    output logic [1:0] state
);

    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int ACW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_EXP   = 2'b11
    } state_t;

    // Key index: 0 = START, 1 = R24, 2 = R14
    logic [2:0]     w_keys;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_deb;
    logic [2:0]     r_press;
    logic [DCW-1:0] r_dcnt [3];

    assign w_keys = {nKEY_R14, nKEY_R24, nKEY_START};

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
            r_deb   <= 3'b111;
            r_press <= 3'b000;
            for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
                        r_deb[i]   <= r_sync2[i];
                        r_dcnt[i]  <= '0;
                        r_press[i] <= ~r_sync2[i];
                    end else begin
                        r_dcnt[i] <= r_dcnt[i] + 1'b1;
                    end
                end else begin
                    r_dcnt[i] <= '0;
                end
            end
        end
    end

    state_t         r_state;
    state_t         w_nstate;
    logic           r_load;
    logic           w_load;
    logic [7:0]     r_load_val;
    logic [7:0]     w_load_val;
    logic           r_cnt_run;
    logic           r_alarm;
    logic           w_alarm;
    logic [ACW-1:0] r_acnt;
    logic [ACW-1:0] w_acnt;
    logic           w_p24;
    logic           w_p14;
    logic           w_rl;
    logic           w_ps;
    logic           w_zero;

    assign w_p24  = r_press[1];
    assign w_p14  = r_press[2] & ~w_p24;
    assign w_rl   = w_p24 | w_p14;
    assign w_ps   = r_press[0] & ~w_rl;
    assign w_zero = (TimerH == 4'd0) && (TimerL == 4'd0);

    always_comb begin
        w_nstate   = r_state;
        w_load     = 1'b0;
        w_load_val = r_load_val;
        w_alarm    = r_alarm;
        w_acnt     = r_acnt;
        if (w_rl) begin
            w_load     = 1'b1;
            w_load_val = w_p24 ? LOAD_LONG : LOAD_SHORT;
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_ps) w_nstate = S_RUN;
            end
            S_RUN: begin
                if (!w_rl) begin
                    if (w_ps) begin
                        w_nstate = S_PAUSE;
                    end else if (w_zero) begin
                        w_nstate = S_EXP;
                        w_alarm  = 1'b1;
                        w_acnt   = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (w_ps) w_nstate = S_RUN;
            end
            S_EXP: begin
                if (w_rl) begin
                    w_nstate = S_IDLE;
                    w_alarm  = 1'b0;
                    w_acnt   = '0;
                end else if (r_alarm && tick) begin
                    if (r_acnt == ACW'(ALARM_TICKS - 1)) begin
                        w_alarm = 1'b0;
                        w_acnt  = '0;
                    end else begin
                        w_acnt = r_acnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_load     <= 1'b0;
            r_load_val <= LOAD_LONG;
            r_cnt_run  <= 1'b0;
            r_alarm    <= 1'b0;
            r_acnt     <= '0;
        end else begin
            r_state    <= w_nstate;
            r_load     <= w_load;
            r_load_val <= w_load_val;
            r_cnt_run  <= (w_nstate == S_RUN);
            r_alarm    <= w_alarm;
            r_acnt     <= w_acnt;
        end
    end

    assign load     = r_load;
    assign load_val = r_load_val;
    assign cnt_run  = r_cnt_run;
    assign Alarm    = r_alarm;
    assign state    = r_state;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl: debounce latency, run/pause,
// expiry horn, reload priority and asynchronous reset.
module tb_shot_clock_ctrl;

    localparam int DEB = 20;

    logic       CLK_50 = 1'b0;
    logic       nRST = 1'b0;
    logic       tick = 1'b0;
    logic       nKEY_START = 1'b1;
    logic       nKEY_R24 = 1'b1;
    logic       nKEY_R14 = 1'b1;
    logic [3:0] TimerH = 4'h1;
    logic [3:0] TimerL = 4'h7;
    logic       load;
    logic [7:0] load_val;
    logic       cnt_run;
    logic       Alarm;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int load_dbl = 0;
    logic prev_load = 1'b0;

    shot_clock_ctrl #(.DEB_CYCLES(DEB)) dut (
        .CLK_50(CLK_50), .nRST(nRST), .tick(tick),
        .nKEY_START(nKEY_START), .nKEY_R24(nKEY_R24),
        .nKEY_R14(nKEY_R14), .TimerH(TimerH), .TimerL(TimerL),
        .load(load), .load_val(load_val), .cnt_run(cnt_run),
        .Alarm(Alarm), .state(state)
    );

    always #10 CLK_50 = ~CLK_50;

    always @(negedge CLK_50) begin
        if (load === 1'b1) load_cnt++;
        if (load === 1'b1 && prev_load === 1'b1) load_dbl++;
        prev_load = load;
    end

    // Hold a key long enough to be accepted, then release it cleanly.
    task automatic press(input int k);
        if (k == 0) nKEY_START = 1'b0;
        if (k == 1) nKEY_R24 = 1'b0;
        if (k == 2) nKEY_R14 = 1'b0;
        repeat (DEB + 6) @(negedge CLK_50);
        nKEY_START = 1'b1;
        nKEY_R24   = 1'b1;
        nKEY_R14   = 1'b1;
        repeat (DEB + 6) @(negedge CLK_50);
    endtask

    task automatic set_timer(input logic [7:0] v);
        TimerH = v[7:4];
        TimerL = v[3:0];
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (3) @(negedge CLK_50);
        nRST = 1'b1;
        repeat (2) @(negedge CLK_50);
        checks++;
        if ({state, cnt_run, load, Alarm} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl got st=%b run=%b ld=%b al=%b exp 00 0 0 0",
                     state, cnt_run, load, Alarm);
        end
        checks++;
        if (load_val !== 8'h24) begin
            errors++;
            $display("FAIL reset_load_val got %h exp 24", load_val);
        end
    endtask

    task automatic test_debounce;
        int n;
        for (int b = 0; b < 3; b++) begin
            nKEY_START = 1'b0;
            repeat (5) @(negedge CLK_50);
            nKEY_START = 1'b1;
            repeat (5) @(negedge CLK_50);
        end
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL bounce_ignored got %b exp 00", state);
        end
        nKEY_START = 1'b0;
        n = 0;
        while (state !== 2'b01 && n < 60) begin
            @(negedge CLK_50);
            n++;
        end
        checks++;
        if (n < DEB + 2 || n > DEB + 4) begin
            errors++;
            $display("FAIL deb_latency got %0d cycles exp %0d..%0d",
                     n, DEB + 2, DEB + 4);
        end
        checks++;
        if (cnt_run !== 1'b1) begin
            errors++;
            $display("FAIL deb_cnt_run got %b exp 1", cnt_run);
        end
        repeat (DEB + 6) @(negedge CLK_50);
        nKEY_START = 1'b1;
        repeat (DEB + 6) @(negedge CLK_50);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL single_press got %b exp 01", state);
        end
    endtask

    task automatic test_run_pause;
        press(0);
        checks++;
        if ({state, cnt_run} !== 3'b100) begin
            errors++;
            $display("FAIL pause got st=%b run=%b exp 10 0", state, cnt_run);
        end
        press(0);
        checks++;
        if ({state, cnt_run} !== 3'b011) begin
            errors++;
            $display("FAIL resume got st=%b run=%b exp 01 1", state, cnt_run);
        end
        press(0);
        set_timer(8'h00);
        repeat (5) @(negedge CLK_50);
        checks++;
        if ({state, Alarm} !== 3'b100) begin
            errors++;
            $display("FAIL pause_zero got st=%b al=%b exp 10 0", state, Alarm);
        end
        set_timer(8'h17);
        press(0);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL rerun got %b exp 01", state);
        end
    endtask

    task automatic test_expiry;
        set_timer(8'h00);
        @(negedge CLK_50);
        checks++;
        if ({state, cnt_run, Alarm} !== 4'b1101) begin
            errors++;
            $display("FAIL expire got st=%b run=%b al=%b exp 11 0 1",
                     state, cnt_run, Alarm);
        end
        for (int t = 1; t <= 3; t++) begin
            repeat (3) @(negedge CLK_50);
            tick = 1'b1;
            @(negedge CLK_50);
            tick = 1'b0;
            @(negedge CLK_50);
            checks++;
            if (Alarm !== (t < 3)) begin
                errors++;
                $display("FAIL horn_tick%0d got %b exp %b", t, Alarm, t < 3);
            end
        end
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL horn_done_state got %b exp 11", state);
        end
        press(0);
        checks++;
        if ({state, Alarm, cnt_run} !== 4'b1100) begin
            errors++;
            $display("FAIL exp_start_ignored got st=%b al=%b run=%b exp 11 0 0",
                     state, Alarm, cnt_run);
        end
    endtask

    task automatic test_reload_expired;
        int n;
        press(1);
        set_timer(8'h17);
        press(0);
        set_timer(8'h00);
        @(negedge CLK_50);
        checks++;
        if ({state, Alarm} !== 3'b111) begin
            errors++;
            $display("FAIL reexpire got st=%b al=%b exp 11 1", state, Alarm);
        end
        load_cnt = 0;
        nKEY_R14 = 1'b0;
        n = 0;
        while (load !== 1'b1 && n < 60) begin
            @(negedge CLK_50);
            n++;
        end
        checks++;
        if ({load, load_val, Alarm, state} !== 12'b1_00010100_0_00) begin
            errors++;
            $display("FAIL r14_reload got ld=%b val=%h al=%b st=%b exp 1 14 0 00",
                     load, load_val, Alarm, state);
        end
        @(negedge CLK_50);
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL r14_pulse_width got %b exp 0", load);
        end
        repeat (DEB + 6) @(negedge CLK_50);
        nKEY_R14 = 1'b1;
        repeat (DEB + 6) @(negedge CLK_50);
        checks++;
        if (load_cnt !== 1) begin
            errors++;
            $display("FAIL r14_count got %0d exp 1", load_cnt);
        end
    endtask

    task automatic test_priority;
        load_cnt = 0;
        nKEY_R24 = 1'b0;
        nKEY_R14 = 1'b0;
        repeat (DEB + 6) @(negedge CLK_50);
        nKEY_R24 = 1'b1;
        nKEY_R14 = 1'b1;
        repeat (DEB + 6) @(negedge CLK_50);
        checks++;
        if ({load_cnt[1:0], load_val} !== {2'd1, 8'h24}) begin
            errors++;
            $display("FAIL prio_24_14 got n=%0d val=%h exp 1 24",
                     load_cnt, load_val);
        end
    endtask

    task automatic test_collision;
        set_timer(8'h17);
        press(0);
        nKEY_R14 = 1'b0;
        repeat (DEB + 2) @(negedge CLK_50);
        set_timer(8'h00);
        @(negedge CLK_50);
        checks++;
        if ({load, load_val, state, Alarm} !== 12'b1_00010100_01_0) begin
            errors++;
            $display("FAIL collide got ld=%b val=%h st=%b al=%b exp 1 14 01 0",
                     load, load_val, state, Alarm);
        end
        set_timer(8'h14);
        @(negedge CLK_50);
        checks++;
        if ({state, cnt_run, Alarm} !== 4'b0110) begin
            errors++;
            $display("FAIL collide_after got st=%b run=%b al=%b exp 01 1 0",
                     state, cnt_run, Alarm);
        end
        repeat (4) @(negedge CLK_50);
        nKEY_R14 = 1'b1;
        repeat (DEB + 6) @(negedge CLK_50);
    endtask

    task automatic test_reset_mid_alarm;
        set_timer(8'h00);
        @(negedge CLK_50);
        checks++;
        if (Alarm !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_alarm got %b exp 1", Alarm);
        end
        load_cnt = 0;
        #3 nRST = 1'b0;
        #1;
        checks++;
        if ({state, Alarm, cnt_run, load} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset got st=%b al=%b run=%b ld=%b exp 00 0 0 0",
                     state, Alarm, cnt_run, load);
        end
        checks++;
        if (load_val !== 8'h24) begin
            errors++;
            $display("FAIL async_reset_val got %h exp 24", load_val);
        end
        repeat (2) @(negedge CLK_50);
        nRST = 1'b1;
        repeat (5) @(negedge CLK_50);
        checks++;
        if ({load_cnt[1:0], state} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset got n=%0d st=%b exp 0 00", load_cnt, state);
        end
        checks++;
        if (load_dbl !== 0) begin
            errors++;
            $display("FAIL load_width got %0d long pulses exp 0", load_dbl);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_run_pause();
        test_expiry();
        test_reload_expired();
        test_priority();
        test_collision();
        test_reset_mid_alarm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
